// File: rtl/operand_hazard_ctrl.sv
// Decode-stage hazard controller: shadow E/M/W writer slots drive stall and
// comparator forwarding selects; a busy countdown sequences the mult/div unit.
module operand_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_is_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  logic [4:0]       e_dst_r, m_dst_r, w_dst_r;
  logic [1:0]       e_tnew_r, m_tnew_r, w_tnew_r;
  logic [CNT_W-1:0] md_cnt_r;
  logic             rs_hz_s, rt_hz_s, md_hz_s, stall_s;
  logic [1:0]       rs_sel_s, rt_sel_s;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    if (t == 2'd0) return 2'd0;
    else           return t - 2'd1;
  endfunction

  // Returns {hazard, select}; nearest matching slot wins, $0 and unread operands never match.
  function automatic logic [2:0] resolve(
    input logic [4:0] r,     input logic [1:0] tuse,
    input logic [4:0] e_dst, input logic [1:0] e_tnew,
    input logic [4:0] m_dst, input logic [1:0] m_tnew,
    input logic [4:0] w_dst, input logic [1:0] w_tnew
  );
    logic [2:0] res;
    res = 3'b000;
    if (tuse == 2'd3 || r == 5'd0) begin
      res = 3'b000;
    end else if (e_dst == r) begin
      res = {(e_tnew > tuse), ((e_tnew == 2'd0) ? 2'd1 : 2'd0)};
    end else if (m_dst == r) begin
      res = {(m_tnew > tuse), ((m_tnew == 2'd0) ? 2'd2 : 2'd0)};
    end else if (w_dst == r) begin
      res = {(w_tnew > tuse), ((w_tnew == 2'd0) ? 2'd3 : 2'd0)};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Operand hazard resolution, md interlock and overall stall.
  always_comb begin
    rs_hz_s  = 1'b0;
    rt_hz_s  = 1'b0;
    rs_sel_s = 2'd0;
    rt_sel_s = 2'd0;
    {rs_hz_s, rs_sel_s} = resolve(d_rs, d_rs_tuse, e_dst_r, e_tnew_r,
                                  m_dst_r, m_tnew_r, w_dst_r, w_tnew_r);
    {rt_hz_s, rt_sel_s} = resolve(d_rt, d_rt_tuse, e_dst_r, e_tnew_r,
                                  m_dst_r, m_tnew_r, w_dst_r, w_tnew_r);
    md_hz_s = (d_md_use | d_md_start) & md_busy;
    stall_s = d_valid & (rs_hz_s | rt_hz_s | md_hz_s);
  end

  assign stall      = stall_s;
  assign fwd_rs_sel = rs_sel_s;
  assign fwd_rt_sel = rt_sel_s;
  assign md_busy    = (md_cnt_r != {CNT_W{1'b0}});

  // Slot shift (E enters only on an unstalled valid issue) and md countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_dst_r  <= 5'd0;
      e_tnew_r <= 2'd0;
      m_dst_r  <= 5'd0;
      m_tnew_r <= 2'd0;
      w_dst_r  <= 5'd0;
      w_tnew_r <= 2'd0;
      md_cnt_r <= {CNT_W{1'b0}};
    end else begin
      m_dst_r  <= e_dst_r;
      m_tnew_r <= tnew_dec(e_tnew_r);
      w_dst_r  <= m_dst_r;
      w_tnew_r <= tnew_dec(m_tnew_r);
      if (d_valid && !stall_s) begin
        e_dst_r  <= d_dst;
        e_tnew_r <= d_tnew;
      end else begin
        e_dst_r  <= 5'd0;
        e_tnew_r <= 2'd0;
      end
      if (d_valid && d_md_start && !stall_s) begin
        md_cnt_r <= d_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_busy) begin
        md_cnt_r <= md_cnt_r - CNT_W'(1);
      end else begin
        md_cnt_r <= md_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Directed bench for operand_hazard_ctrl: load-use, ALU-use, forwarding
// priority, $0 handling, md sequencing and asynchronous reset.
module tb_operand_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_md_start, d_md_is_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  int         total = 0;
  int         bad = 0;
  int         n;

  operand_hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_is_div(d_md_is_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rs_tu, input logic [1:0] rt_tu,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic mds, input logic mdd, input logic mdu);
    d_valid = v; d_rs = rs; d_rt = rt; d_rs_tuse = rs_tu; d_rt_tuse = rt_tu;
    d_dst = dst; d_tnew = tn; d_md_start = mds; d_md_is_div = mdd; d_md_use = mdu;
  endtask

  task automatic nop();
    set_d(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Counts stall cycles for the instruction currently held in D, bounded.
  task automatic count_stalls(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (!stall) break;
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    nop();
    #2;
    // Reset with random operand fields but no valid instruction.
    set_d(1'b0, 5'($urandom), 5'($urandom), 2'd0, 2'd0, 5'($urandom), 2'd2, 1'b1, 1'b1, 1'b1);
    tick(); look();
    check("rst_stall", stall, 0);
    check("rst_fwd_rs", fwd_rs_sel, 0);
    check("rst_fwd_rt", fwd_rt_sel, 0);
    check("rst_md_busy", md_busy, 0);
    tick();
    reset = 1'b0;
    nop();

    // lw $5 then beq $5,$0: two stalls, then the value is in W.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    look(); check("lw_issue_stall", stall, 0);
    tick(); set_d(1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    look(); check("lw_use_stall1", stall, 1);
    tick(); look(); check("lw_use_stall2", stall, 1);
    tick(); look(); check("lw_use_go", stall, 0);
    check("lw_use_fwd_rs", fwd_rs_sel, 3);
    check("lw_use_fwd_rt_zero", fwd_rt_sel, 0);

    // addu $3 then beq $3,$3: one stall, then both from M.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd3, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    look(); check("alu_use_stall", stall, 1);
    tick(); look(); check("alu_use_go", stall, 0);
    check("alu_fwd_rs", fwd_rs_sel, 2);
    check("alu_fwd_rt", fwd_rt_sel, 2);

    // Two writers of $4 (E and M, tnew 0): E wins.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    look(); check("prio_stall", stall, 0);
    check("prio_fwd_rs_e", fwd_rs_sel, 1);

    // Writers with dst 0 and slow tnew: reading $0 never stalls or forwards.
    tick(); nop(); tick(); tick(); tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    look(); check("zero_stall", stall, 0);
    check("zero_fwd_rs", fwd_rs_sel, 0);
    check("zero_fwd_rt", fwd_rt_sel, 0);

    // div then mflo: 10 stall cycles.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    look(); check("div_issue_busy", md_busy, 0);
    check("div_issue_stall", stall, 0);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    look(); check("div_busy_next", md_busy, 1);
    count_stalls(n);
    check("div_stall_cycles", n, 10);
    check("div_busy_done", md_busy, 0);

    // mult then mflo: 5 stall cycles.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    count_stalls(n);
    check("mult_stall_cycles", n, 5);

    // div then mult while busy: mult waits out the div, then loads 5.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    count_stalls(n);
    check("md_issue_blocked_cycles", n, 10);
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    count_stalls(n);
    check("md_after_block_cycles", n, 5);

    // Async reset during a load-use stall.
    tick(); set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    tick(); set_d(1'b1, 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    look(); check("pre_rst_stall", stall, 1);
    #1 reset = 1'b1;
    #1 check("async_rst_stall", stall, 0);
    tick(); reset = 1'b0;
    look(); check("post_rst_stall", stall, 0);
    check("post_rst_fwd_rs", fwd_rs_sel, 0);
    check("post_rst_md_busy", md_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
